// File: rtl/axi_uncached_wbuf.sv
// ============================================================================
// axi_uncached_wbuf : posted write buffer retiring uncached stores to AXI
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_uncached_wbuf #(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    // CPU store port
    input  logic        req,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    // load hazard check
    input  logic [31:0] chk_addr,
    output logic        chk_hit,
    output logic        empty,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [3:0]  wid,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [31:0] ent_addr_q [DEPTH];
    logic [1:0]  ent_size_q [DEPTH];
    logic [3:0]  ent_strb_q [DEPTH];
    logic [31:0] ent_data_q [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic          data_ok_q;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [31:0]   awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [1:0]    awsize_q, awsize_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          push, pop;
    logic [DEPTH-1:0] occ;

    assign addr_ok = req & (count_q != CW'(DEPTH));
    assign push    = req & addr_ok;

    always_ff @(posedge aclk) begin
        if (push) begin
            ent_addr_q[tail_q] <= addr;
            ent_size_q[tail_q] <= size;
            ent_strb_q[tail_q] <= wstrb;
            ent_data_q[tail_q] <= wdata;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    assign tail_d  = push ? tail_q + 1'b1 : tail_q;
    assign head_d  = pop  ? head_q + 1'b1 : head_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        awsize_d  = awsize_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    awaddr_d  = ent_addr_q[head_q];
                    awsize_d  = ent_size_q[head_q];
                    wdata_d   = ent_data_q[head_q];
                    wstrb_d   = ent_strb_q[head_q];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (bvalid && bready_q) begin
                    pop      = 1'b1;
                    bready_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            data_ok_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            data_ok_q <= push;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            awsize_q  <= awsize_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // An entry stays visible to the hazard check until its B response pops it.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ({1'b0, PW'(i) - head_q} < count_q);
        end
    end

    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (ent_addr_q[i][31:2] == chk_addr[31:2])) chk_hit = 1'b1;
        end
    end

    assign data_ok = data_ok_q;
    assign empty   = (count_q == '0) && (state_q == S_IDLE);

    assign awid    = AXI_ID;
    assign awaddr  = awaddr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, awsize_q};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q;

    assign wid     = AXI_ID;
    assign wdata_o = wdata_q;
    assign wstrb_o = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;

    assign bready  = bready_q;

    logic unused_sigs;
    assign unused_sigs = ^{bid, bresp, chk_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_axi_uncached_wbuf.sv
// ============================================================================
// tb_axi_uncached_wbuf : scoreboard bench for the uncached write buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_uncached_wbuf;

    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok, data_ok;
    logic [31:0] chk_addr;
    logic        chk_hit, empty;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_uncached_wbuf #(.DEPTH(DEPTH), .AXI_ID(4'd1)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .req(req), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  s;
        logic [3:0]  st;
        logic [31:0] d;
    } ent_t;

    ent_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic b_en, b_rand;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // B-channel responder: raises bvalid once bready is seen, optionally after a random delay.
    initial begin
        bvalid = 1'b0;
        forever begin
            @(negedge aclk);
            bvalid = bready && b_en && (bvalid || !b_rand || ($urandom_range(0, 1) == 1));
        end
    end

    // Monitor: reference occupancy model plus in-order scoreboard of pushed stores.
    initial begin
        ent_t e, cur;
        int   mcnt;
        logic prev_push, m_push, aw_seen;
        mcnt = 0; prev_push = 1'b0; aw_seen = 1'b0; cur = '0;
        forever begin
            @(negedge aclk);
            #4;
            if (!aresetn) begin
                sb_q.delete();
                mcnt = 0; prev_push = 1'b0; aw_seen = 1'b0;
            end else begin
                m_push = req && (mcnt != DEPTH);
                check("data_ok", 32'(data_ok), 32'(prev_push));
                check("addr_ok", 32'(addr_ok), 32'(m_push));
                if (wvalid && wready) begin
                    check("w_sb_nonempty", 32'(aw_seen || sb_q.size() != 0), 32'd1);
                    e = aw_seen ? cur : ((sb_q.size() != 0) ? sb_q[0] : '0);
                    check("wdata", wdata_o, e.d);
                    check("wstrb", 32'(wstrb_o), 32'(e.st));
                end
                if (awvalid && awready) begin
                    check("aw_sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
                    check("awaddr", awaddr, e.a);
                    check("awsize", 32'(awsize), {29'd0, 1'b0, e.s});
                    check("axi_const", {4'd0, awlen, awburst, awlock, awcache, awprot, awid, wid, wlast},
                          {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 4'd1, 1'b1});
                    cur = e;
                    aw_seen = 1'b1;
                end
                if (bvalid && bready) begin
                    mcnt--;
                    aw_seen = 1'b0;
                end
                if (m_push) begin
                    sb_q.push_back({addr, size, wstrb, wdata});
                    mcnt++;
                end
                prev_push = m_push;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [3:0] st, input logic [31:0] d);
        int n;
        req = 1'b1; addr = a; size = s; wstrb = st; wdata = d;
        n = 0;
        #2;
        while (!addr_ok && n < 200) begin
            n++;
            @(negedge aclk);
            #2;
        end
        check("accept", 32'(addr_ok), 32'd1);
        @(negedge aclk);
        req = 1'b0;
    endtask

    // which: 0 = awvalid, 1 = bready, 2 = empty
    task automatic wait_for(input string tag, input int which);
        int   n;
        logic v;
        n = 0;
        #2;
        v = (which == 0) ? awvalid : (which == 1) ? bready : empty;
        while (!v && n < 200) begin
            n++;
            @(negedge aclk);
            #2;
            v = (which == 0) ? awvalid : (which == 1) ? bready : empty;
        end
        check(tag, 32'(v), 32'd1);
        @(negedge aclk);
    endtask

    initial begin
        aresetn = 1'b0; req = 1'b0; size = '0; addr = '0; wstrb = '0; wdata = '0;
        chk_addr = '0; awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'b00;
        b_en = 1'b0; b_rand = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        #2;
        check("rst_addr_ok", 32'(addr_ok), 32'd0);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
        check("rst_chk_hit", 32'(chk_hit), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        @(negedge aclk);

        // single word store
        awready = 1'b1; wready = 1'b1; b_en = 1'b1;
        store(32'hBFAF_F020, 2'd2, 4'hF, 32'h1234_5678);
        wait_for("single_empty", 2);

        // fill to full with AW stalled, then drain
        awready = 1'b0; wready = 1'b0;
        for (int i = 0; i < DEPTH; i++) store(32'h3000_0000 + 32'(i * 4), 2'(i % 3), 4'(1 << i), 32'hC0DE_0000 + 32'(i));
        chk_addr = 32'h3000_000E;
        #1 check("hit_tail", 32'(chk_hit), 32'd1);
        chk_addr = 32'h3000_0010;
        #1 check("miss_beyond", 32'(chk_hit), 32'd0);
        @(negedge aclk);
        req = 1'b1; addr = 32'h3000_0040; size = 2'd2; wstrb = 4'hF; wdata = 32'hFEED_0005;
        repeat (3) begin
            #2 check("full_addr_ok", 32'(addr_ok), 32'd0);
            @(negedge aclk);
        end
        awready = 1'b1; wready = 1'b1;
        store(32'h3000_0040, 2'd2, 4'hF, 32'hFEED_0005);
        wait_for("fill_empty", 2);

        // split AW/W handshake
        awready = 1'b0; wready = 1'b0;
        store(32'h4000_0010, 2'd1, 4'b1100, 32'hABCD_0000);
        wait_for("split_awvalid", 0);
        awready = 1'b1;
        @(negedge aclk);
        awready = 1'b0;
        #2 check("split_c1", {29'd0, awvalid, wvalid, bready}, 32'b010);
        @(negedge aclk);
        #2 check("split_c2", {29'd0, awvalid, wvalid, bready}, 32'b010);
        @(negedge aclk);
        wready = 1'b1;
        @(negedge aclk);
        wready = 1'b0;
        #2 check("split_c3", {29'd0, awvalid, wvalid, bready}, 32'b001);
        @(negedge aclk);
        wait_for("split_empty", 2);

        // hazard check on an in-flight byte store
        awready = 1'b1; wready = 1'b1; b_en = 1'b0;
        store(32'h1000_0004, 2'd0, 4'b0001, 32'h0000_00AA);
        repeat (3) @(negedge aclk);
        chk_addr = 32'h1000_0007;
        #1 check("hz_same_word", 32'(chk_hit), 32'd1);
        chk_addr = 32'h1000_0008;
        #1 check("hz_next_word", 32'(chk_hit), 32'd0);
        chk_addr = 32'h1000_0004;
        #1 check("hz_inflight", 32'(chk_hit), 32'd1);
        @(negedge aclk);
        b_en = 1'b1;
        wait_for("hz_empty", 2);
        #1 check("hz_after_pop", 32'(chk_hit), 32'd0);
        @(negedge aclk);

        // full buffer with concurrent push/pop, 8 stores wrap the pointers
        b_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == DEPTH) begin b_en = 1'b1; b_rand = 1'b1; end
            store(32'h5000_0000 + 32'(i * 8), 2'($urandom_range(0, 2)), 4'($urandom_range(1, 15)), $urandom);
        end
        wait_for("wrap_empty", 2);
        b_rand = 1'b0;

        // reset while waiting for B
        b_en = 1'b0;
        store(32'h6000_0000, 2'd2, 4'hF, 32'h1111_1111);
        store(32'h6000_0004, 2'd2, 4'hF, 32'h2222_2222);
        wait_for("rst_resp_bready", 1);
        #1 aresetn = 1'b0;
        #1;
        check("async_rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        b_en = 1'b1;
        store(32'h7000_0008, 2'd2, 4'hF, 32'h3333_3333);
        wait_for("post_rst_empty", 2);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
